data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 17 +
 rtl/data_mem_ctrl.sv | 111 +++++++++++
 tb/tb_data_mem_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between a bus master and data_mem_ctrl.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 32
);
  logic                  req;
  logic                  we;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     wd;
  logic [DATA_W/8-1:0]   be;
  logic                  busy;
  logic                  done;
  logic [DATA_W-1:0]     rd;
  logic                  err;

  modport master (output req, we, addr, wd, be, input busy, done, rd, err);
  modport slave  (input req, we, addr, wd, be, output busy, done, rd, err);
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller with fixed wait states, byte-masked
// writes, registered read data and one-cycle done/err pulses.
module data_mem_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int WAIT_CYC   = 2
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_ctrl_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  we_q, we_d;
  logic [DATA_W-1:0]     wd_q, wd_d;
  logic [NB-1:0]         be_q, be_d;
  logic [DATA_W-1:0]     rd_q, rd_d;
  logic                  err_q, err_d;
  logic                  mem_wr;
  logic                  addr_bad;

  // Storage is deliberately not reset; only control state is.
  logic [DATA_W-1:0]     mem [DEPTH];

  // Misaligned or beyond-the-array addresses are rejected at accept time.
  assign addr_bad = (bus.addr[1:0] != 2'b00) || (bus.addr[31:DEPTH_LOG2+2] != '0);

  // Next-state, operand capture and access strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wd_d    = wd_q;
    be_d    = be_q;
    rd_d    = rd_q;
    err_d   = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      S_WAIT: begin
        // Operands are frozen here; req is ignored while busy.
        if (cnt_q == 3'd0) begin
          state_d = S_DONE;
          if (we_q) mem_wr = 1'b1;
          else      rd_d   = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
        state_d = S_IDLE;
        if (bus.req) begin
          idx_d = bus.addr[DEPTH_LOG2+1:2];
          we_d  = bus.we;
          wd_d  = bus.wd;
          be_d  = bus.be;
          if (addr_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(WAIT_CYC);
          end
        end
      end
    endcase
  end

  // Control and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Byte-masked write commit on the edge that leaves WAIT.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
      end
    end
  end

  assign bus.busy = (state_q == S_WAIT);
  assign bus.done = (state_q == S_DONE);
  assign bus.err  = err_q;
  assign bus.rd   = rd_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: two controllers (WAIT_CYC=2 and WAIT_CYC=0) see the same
// request stream; expected completions are queued at issue time and checked
// by a negedge monitor against a word-array reference model.
module tb_data_mem_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  data_mem_ctrl_if #(.DATA_W(32)) bus2();
  data_mem_ctrl_if #(.DATA_W(32)) bus0();

  assign bus0.req  = bus2.req;
  assign bus0.we   = bus2.we;
  assign bus0.addr = bus2.addr;
  assign bus0.wd   = bus2.wd;
  assign bus0.be   = bus2.be;

  data_mem_ctrl #(.DATA_W(32), .DEPTH_LOG2(6), .WAIT_CYC(2)) u_dut2 (
    .clk(clk), .reset(rst_n), .bus(bus2));
  data_mem_ctrl #(.DATA_W(32), .DEPTH_LOG2(6), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0));

  typedef struct {
    int          cyc;     // edge after which the done/err pulse is visible
    bit          is_err;
    bit          we;
    int          idx;
    logic [31:0] wd;
    logic [3:0]  be;
  } txn_t;

  // index 0 -> u_dut2, index 1 -> u_dut0
  int          wc [2] = '{2, 0};
  txn_t        qa[$], qb[$];
  logic [31:0] ref_mem [2][64];
  logic [31:0] exp_rd [2];
  int          free_e [2];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @edge %0d: got %h expected %h", name, j, edge_n, act, exp);
    end
  endtask

  // Issue one cycle of inputs; the model decides acceptance from its own timeline.
  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    int   k;
    txn_t t;
    bus2.req = r; bus2.we = w; bus2.addr = a; bus2.wd = d; bus2.be = b;
    k = edge_n + 1;
    for (int j = 0; j < 2; j++) begin
      if (r && k >= free_e[j]) begin
        t.is_err = (a[1:0] != 2'b00) || (a[31:8] != 24'h0);
        t.we = w; t.idx = int'(a[7:2]); t.wd = d; t.be = b;
        if (t.is_err) begin
          t.cyc = k;                free_e[j] = k + 1;
        end else begin
          t.cyc = k + wc[j] + 1;    free_e[j] = k + wc[j] + 2;
        end
        if (j == 0) qa.push_back(t); else qb.push_back(t);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
      idle();
      n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL drain timeout: got %0d/%0d pending expected 0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b1, w, a, d, b);
    drain();
  endtask

  // Per-DUT monitor step: expected pulses/busy come from the queued head.
  task automatic mon(input int j, input logic busy, input logic done, input logic err,
                     input logic [31:0] rd);
    txn_t t;
    bit   has;
    logic eb, ed, ee;
    has = (j == 0) ? (qa.size() != 0) : (qb.size() != 0);
    if (has) begin
      if (j == 0) t = qa[0]; else t = qb[0];
    end
    eb = has && !t.is_err && edge_n >= t.cyc - wc[j] - 1 && edge_n < t.cyc;
    ed = has && !t.is_err && edge_n == t.cyc;
    ee = has &&  t.is_err && edge_n == t.cyc;
    if (ed) begin
      if (t.we) begin
        for (int b = 0; b < 4; b++)
          if (t.be[b]) ref_mem[j][t.idx][8*b +: 8] = t.wd[8*b +: 8];
      end else begin
        exp_rd[j] = ref_mem[j][t.idx];
      end
    end
    if (ed || ee) begin
      if (j == 0) void'(qa.pop_front()); else void'(qb.pop_front());
    end
    chk("busy", j, 32'(busy), 32'(eb));
    chk("done", j, 32'(done), 32'(ed));
    chk("err",  j, 32'(err),  32'(ee));
    chk("rd",   j, rd, exp_rd[j]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bus2.busy, bus2.done, bus2.err, bus2.rd);
      mon(1, bus0.busy, bus0.done, bus0.err, bus0.rd);
    end
  end

  task automatic chk_reset_outputs(input string name);
    chk({name, "_busy"}, 0, 32'(bus2.busy), 32'd0);
    chk({name, "_done"}, 0, 32'(bus2.done), 32'd0);
    chk({name, "_err"},  0, 32'(bus2.err),  32'd0);
    chk({name, "_rd"},   0, bus2.rd, 32'd0);
    chk({name, "_busy"}, 1, 32'(bus0.busy), 32'd0);
    chk({name, "_done"}, 1, 32'(bus0.done), 32'd0);
    chk({name, "_err"},  1, 32'(bus0.err),  32'd0);
    chk({name, "_rd"},   1, bus0.rd, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    bus2.req = 1'b0; bus2.we = 1'b0; bus2.addr = '0; bus2.wd = '0; bus2.be = '0;
    exp_rd = '{default: 32'h0};
    free_e = '{default: 0};
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Give every word a known value.
    for (int i = 0; i < 64; i++) op(1'b1, 32'(i) << 2, $urandom, 4'hF);

    // Full write, read back, single-byte merge.
    op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    op(1'b0, 32'h10, $urandom, 4'h0);
    chk("rd_deadbeef", 0, bus2.rd, 32'hDEADBEEF);
    op(1'b1, 32'h10, 32'h000000AA, 4'h1);
    op(1'b0, 32'h10, $urandom, 4'h0);
    chk("rd_merged", 0, bus2.rd, 32'hDEADBEAA);
    // Rejected requests, then be=0 write; memory must be untouched.
    op(1'b1, 32'h12, 32'h11111111, 4'hF);
    op(1'b1, 32'h100, 32'h22222222, 4'hF);
    op(1'b0, 32'h12, $urandom, 4'h0);
    op(1'b1, 32'h10, 32'h33333333, 4'h0);
    op(1'b0, 32'h10, $urandom, 4'h0);
    chk("rd_unchanged", 0, bus2.rd, 32'hDEADBEAA);
    chk("rd_unchanged", 1, bus0.rd, 32'hDEADBEAA);

    // req held high with reads: back-to-back throughput, busy-time requests ignored.
    for (int i = 0; i < 24; i++)
      drive(1'b1, 1'b0, {24'h0, 6'($urandom), 2'b00}, $urandom, 4'($urandom));
    drain();

    // Random mix of reads, writes, bad addresses and idle cycles.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       a = {24'h0, 6'($urandom), 2'($urandom_range(1, 3))};
        1:       a = $urandom | 32'h100;
        default: a = {24'h0, 6'($urandom), 2'b00};
      endcase
      drive(1'($urandom_range(0, 2) != 0), 1'($urandom), a, $urandom, 4'($urandom));
    end
    drain();

    // Reset in the second WAIT cycle of a write aborts it on the slow DUT.
    op(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    drive(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    qa.delete(); qb.delete();
    exp_rd = '{default: 32'h0};
    free_e = '{default: 0};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    op(1'b0, 32'h20, $urandom, 4'h0);
    chk("rd_after_abort", 0, bus2.rd, 32'hCAFEF00D);
    chk("rd_after_abort", 1, bus0.rd, 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
